// File: rtl/pwm_capture.sv
// Eight-channel PWM period/high-time measurement block with a byte-addressed
// register bus (12 bytes per channel: CTRL/STAT, PERIOD, HIGH).
module pwm_capture #(
  parameter int NCH  = 8,
  parameter int CW   = 32,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd,
  input  logic           wr,
  input  logic [6:0]     adrs,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  input  logic [NCH-1:0] pwmi,
  output logic           irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [SYNC-1:0] sync_q [NCH];
  logic [SYNC-1:0] sync_d [NCH];
  logic [NCH-1:0]  prev_q, prev_d;
  logic [NCH-1:0]  en_q, en_d, ie_q, ie_d;
  logic [NCH-1:0]  valid_q, valid_d, ovf_q, ovf_d;
  logic [NCH-1:0]  level, rise, fall, wr_ctrl;
  logic [1:0]      state_q [NCH];
  logic [1:0]      state_d [NCH];
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [CW-1:0]   hcap_q [NCH];
  logic [CW-1:0]   hcap_d [NCH];
  logic [CW-1:0]   period_q [NCH];
  logic [CW-1:0]   period_d [NCH];
  logic [CW-1:0]   high_q [NCH];
  logic [CW-1:0]   high_d [NCH];
  logic [31:0]     dout_q, dout_d, rdata;
  logic            irq_q, irq_d;

  // Synchronizer chain and edge detection on the synchronized level.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sync_d[c] = {sync_q[c][SYNC-2:0], pwmi[c]};
      level[c]  = sync_q[c][SYNC-1];
      rise[c]   = level[c] & ~prev_q[c];
      fall[c]   = ~level[c] & prev_q[c];
      prev_d[c] = level[c];
      wr_ctrl[c] = wr && (adrs == 7'(12 * c));
    end
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    valid_d = valid_q & ~({NCH{1'b0}} | (wr_ctrl & {NCH{din[1]}}));
    ovf_d   = ovf_q & ~(wr_ctrl & {NCH{din[2]}});
    for (int c = 0; c < NCH; c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      hcap_d[c]   = hcap_q[c];
      period_d[c] = period_q[c];
      high_d[c]   = high_q[c];
      if (wr_ctrl[c]) begin
        en_d[c] = din[0];
        ie_d[c] = din[4];
      end
      // Flag sets come after the W1C clear so a same-cycle set wins.
      if (!en_q[c]) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            cnt_d[c]   = '0;
            state_d[c] = ST_ARM;
          end
          ST_ARM: begin
            if (rise[c]) begin
              state_d[c] = ST_MEAS;
              cnt_d[c]   = CW'(1);
            end else if (cnt_q[c] == CNT_MAX) begin
              ovf_d[c] = 1'b1;
              cnt_d[c] = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CW'(1);
            end
          end
          ST_MEAS: begin
            if (fall[c]) hcap_d[c] = cnt_q[c];
            if (rise[c]) begin
              period_d[c] = cnt_q[c];
              high_d[c]   = hcap_q[c];
              valid_d[c]  = 1'b1;
              cnt_d[c]    = CW'(1);
            end else if (cnt_q[c] == CNT_MAX) begin
              ovf_d[c]   = 1'b1;
              state_d[c] = ST_ARM;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CW'(1);
            end
          end
          default: begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
          end
        endcase
      end
    end
  end

  // Read mux: registers sit at 4-byte aligned offsets, everything else reads 0.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (adrs == 7'(12 * c))
        rdata = {27'd0, ie_q[c], level[c], ovf_q[c], valid_q[c], en_q[c]};
      else if (adrs == 7'(12 * c + 4))
        rdata = 32'(period_q[c]);
      else if (adrs == 7'(12 * c + 8))
        rdata = 32'(high_q[c]);
    end
    dout_d = rd ? rdata : dout_q;
    irq_d  = |(ie_q & valid_q);
  end

  // NOTE: sequential state uses non-blocking assignments only; the per-channel
  // arrays are ordinary flops, so they are reset like any other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= '0;
      en_q    <= '0;
      ie_q    <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      dout_q  <= '0;
      irq_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        sync_q[c]   <= '0;
        state_q[c]  <= ST_IDLE;
        cnt_q[c]    <= '0;
        hcap_q[c]   <= '0;
        period_q[c] <= '0;
        high_q[c]   <= '0;
      end
    end else begin
      prev_q  <= prev_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      irq_q   <= irq_d;
      for (int c = 0; c < NCH; c++) begin
        sync_q[c]   <= sync_d[c];
        state_q[c]  <= state_d[c];
        cnt_q[c]    <= cnt_d[c];
        hcap_q[c]   <= hcap_d[c];
        period_q[c] <= period_d[c];
        high_q[c]   <= high_d[c];
      end
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CW=8 so overflow is reachable quickly).
module tb_pwm_capture;

  localparam int NCH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [6:0]  adrs;
  logic [31:0] din;
  logic [31:0] dout;
  logic [NCH-1:0] pwmi;
  logic        irq;

  logic [NCH-1:0] gen_on  = '0;
  logic [NCH-1:0] gen_out = '0;
  logic [NCH-1:0] man     = '0;
  int gp [NCH];
  int gh [NCH];
  int ph [NCH];

  int total = 0;
  int bad   = 0;
  logic [31:0] v;

  pwm_capture #(.NCH(NCH), .CW(8), .SYNC(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .rd   (rd),
    .wr   (wr),
    .adrs (adrs),
    .din  (din),
    .dout (dout),
    .pwmi (pwmi),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  assign pwmi = (gen_on & gen_out) | (~gen_on & man);

  initial begin
    for (int c = 0; c < NCH; c++) begin
      gp[c] = 1;
      gh[c] = 0;
      ph[c] = 0;
    end
  end

  // Free-running per-channel generators: period gp cycles, first gh cycles high.
  always begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (gen_on[c]) begin
        ph[c] = (ph[c] + 1 >= gp[c]) ? 0 : ph[c] + 1;
        gen_out[c] = (ph[c] < gh[c]);
      end else begin
        ph[c] = gp[c] - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [31:0] d);
    adrs = a;
    din  = d;
    wr   = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [6:0] a, output logic [31:0] d);
    adrs = a;
    rd   = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    d  = dout;
  endtask

  task automatic pulse(input int c, input int h, input int l);
    man[c] = 1'b1;
    wait_cyc(h);
    man[c] = 1'b0;
    wait_cyc(l);
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; adrs = '0; din = '0;
    man[7] = 1'b1;
    wait_cyc(3);
    check("rst_dout", dout, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    rst = 1'b1;
    rd_reg(7'h00, v); check("rst_ctrl0", v, 32'h0);
    rd_reg(7'h58, v); check("rst_period7", v, 32'h0);

    // Basic measurement on ch0 (20/5) and ch1 (7/3).
    gp[0] = 20; gh[0] = 5; gen_on[0] = 1'b1;
    gp[1] = 7;  gh[1] = 3; gen_on[1] = 1'b1;
    wr_reg(7'h00, 32'h01);
    wr_reg(7'h0C, 32'h01);
    wait_cyc(100);
    rd_reg(7'h04, v); check("ch0_period", v, 32'd20);
    rd_reg(7'h08, v); check("ch0_high", v, 32'd5);
    rd_reg(7'h00, v); check("ch0_ctrl", v & 32'hFFFF_FFF7, 32'h03);
    rd_reg(7'h10, v); check("ch1_period", v, 32'd7);
    rd_reg(7'h14, v); check("ch1_high", v, 32'd3);

    // Interrupt, W1C clear, and set-beats-clear collision on ch0.
    wr_reg(7'h00, 32'h11);
    wait_cyc(2);
    check("irq_set", {31'd0, irq}, 32'h1);
    gen_on[0] = 1'b0;
    wait_cyc(5);
    wr_reg(7'h00, 32'h13);
    check("irq_lag", {31'd0, irq}, 32'h1);
    wait_cyc(1);
    check("irq_clr", {31'd0, irq}, 32'h0);
    man[0] = 1'b1;
    wait_cyc(2);
    wr_reg(7'h00, 32'h13);
    rd_reg(7'h00, v); check("collision_ctrl", v, 32'h1B);
    wait_cyc(1);
    check("irq_reassert", {31'd0, irq}, 32'h1);

    // Overflow on ch7 with input held high.
    wr_reg(7'h54, 32'h01);
    wait_cyc(240);
    rd_reg(7'h54, v); check("ovf_before", v, 32'h09);
    wait_cyc(30);
    rd_reg(7'h54, v); check("ovf_after", v, 32'h0D);
    rd_reg(7'h58, v); check("ovf_period", v, 32'h0);
    gp[7] = 10; gh[7] = 4; gen_on[7] = 1'b1;
    wait_cyc(60);
    rd_reg(7'h58, v); check("ch7_period", v, 32'd10);
    rd_reg(7'h5C, v); check("ch7_high", v, 32'd4);
    rd_reg(7'h54, v); check("ch7_flags", v & 32'h7, 32'h7);

    // Manual pulses on ch2: arm, capture, disable, re-enable.
    wr_reg(7'h18, 32'h01);
    wait_cyc(2);
    pulse(2, 3, 5);
    pulse(2, 3, 5);
    wait_cyc(2);
    rd_reg(7'h1C, v); check("ch2_period", v, 32'd8);
    rd_reg(7'h20, v); check("ch2_high", v, 32'd3);
    rd_reg(7'h18, v); check("ch2_valid", v & 32'h7, 32'h3);
    wr_reg(7'h18, 32'h02);
    pulse(2, 4, 4);
    pulse(2, 4, 4);
    rd_reg(7'h1C, v); check("dis_period", v, 32'd8);
    rd_reg(7'h20, v); check("dis_high", v, 32'd3);
    rd_reg(7'h18, v); check("dis_ctrl", v & 32'h17, 32'h0);
    wr_reg(7'h18, 32'h01);
    wait_cyc(2);
    pulse(2, 2, 4);
    wait_cyc(2);
    rd_reg(7'h18, v); check("arm_novalid", v & 32'h2, 32'h0);
    rd_reg(7'h1C, v); check("arm_period", v, 32'd8);
    pulse(2, 2, 4);
    wait_cyc(2);
    rd_reg(7'h1C, v); check("reen_period", v, 32'd10);
    rd_reg(7'h20, v); check("reen_high", v, 32'd2);
    rd_reg(7'h18, v); check("reen_ctrl", v & 32'h3, 32'h3);

    // Bus boundaries and simultaneous read/write.
    wr_reg(7'h10, 32'h55);
    rd_reg(7'h10, v); check("ro_period", v, 32'd7);
    rd_reg(7'h60, v); check("unmapped_60", v, 32'h0);
    rd_reg(7'h02, v); check("unmapped_02", v, 32'h0);
    adrs = 7'h18; din = 32'h0; rd = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    check("rdwr_prewrite", dout & 32'h1, 32'h1);
    rd_reg(7'h18, v); check("rdwr_postwrite", v & 32'h1, 32'h0);

    // Asynchronous reset mid-measurement.
    rd_reg(7'h10, v); check("pre_rst_dout", v, 32'd7);
    check("pre_rst_irq", {31'd0, irq}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_dout", dout, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    wait_cyc(1);
    rst = 1'b1;
    rd_reg(7'h04, v); check("post_rst_period", v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
